// File: rtl/time_parameter_timer_if.sv
// Bus between the anti-theft controller / owner programming path and the time-parameter timer.
// The master drives requests and the slave (the timer) returns read data and status.
interface time_parameter_timer_if #(
   parameter int SEL_WIDTH   = 2,
   parameter int VALUE_WIDTH = 4
);
   logic                   oneHzEnable;
   logic                   reprogram;
   logic [SEL_WIDTH-1:0]   timeParameterSelector;
   logic [VALUE_WIDTH-1:0] timeValue;
   logic [SEL_WIDTH-1:0]   interval;
   logic [VALUE_WIDTH-1:0] value;
   logic                   startTimer;
   logic                   doubleTime;
   logic                   abortTimer;
   logic [VALUE_WIDTH:0]   remaining;
   logic                   timerBusy;
   logic                   expired;
   logic                   programError;

   modport master (
      output oneHzEnable, reprogram, timeParameterSelector, timeValue, interval,
             startTimer, doubleTime, abortTimer,
      input  value, remaining, timerBusy, expired, programError
   );

   modport slave (
      input  oneHzEnable, reprogram, timeParameterSelector, timeValue, interval,
             startTimer, doubleTime, abortTimer,
      output value, remaining, timerBusy, expired, programError
   );
endinterface

// File: rtl/time_parameter_timer.sv
// Reprogrammable time-parameter store with an integrated seconds countdown timer.
// The timer loads the selected parameter (optionally doubled) and pulses expired on reaching zero.
module time_parameter_timer #(
   parameter int                              NUM_PARAMS  = 4,
   parameter int                              SEL_WIDTH   = 2,
   parameter int                              VALUE_WIDTH = 4,
   parameter logic [NUM_PARAMS*VALUE_WIDTH-1:0] DEFAULTS  = {4'd10, 4'd15, 4'd8, 4'd6}
) (
   input logic clock,
   input logic systemReset,
   time_parameter_timer_if.slave bus
);
   typedef enum logic {IDLE, COUNTING} state_t;

   state_t                 state_reg, state_next;
   logic [VALUE_WIDTH:0]   remaining_reg, remaining_next;
   logic                   expired_reg, expired_next;
   logic                   program_error_reg;
   logic                   write_reject;
   logic [VALUE_WIDTH:0]   load_value;
   logic [VALUE_WIDTH-1:0] regs_reg [NUM_PARAMS];

   assign write_reject = (bus.timeValue == '0) ||
                         (int'(bus.timeParameterSelector) >= NUM_PARAMS);

   generate
      for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
         always_ff @(posedge clock) begin
            if (systemReset)
               regs_reg[gi] <= DEFAULTS[gi*VALUE_WIDTH +: VALUE_WIDTH];
            else if (bus.reprogram && !write_reject &&
                     bus.timeParameterSelector == SEL_WIDTH'(gi))
               regs_reg[gi] <= bus.timeValue;
         end
      end
   endgenerate

   // Out-of-range selectors read as zero, which the timer treats as an immediate expiry.
   always_comb begin
      bus.value = '0;
      for (int i = 0; i < NUM_PARAMS; i++)
         if (bus.interval == SEL_WIDTH'(i))
            bus.value = regs_reg[i];
   end

   assign load_value = bus.doubleTime ? {bus.value, 1'b0} : {1'b0, bus.value};

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      expired_next   = 1'b0;
      if (bus.abortTimer) begin
         state_next     = IDLE;
         remaining_next = '0;
      end else if (bus.startTimer) begin
         // A restart while counting swallows any tick arriving in the same cycle.
         if (load_value == '0) begin
            state_next     = IDLE;
            remaining_next = '0;
            expired_next   = 1'b1;
         end else begin
            state_next     = COUNTING;
            remaining_next = load_value;
         end
      end else if (state_reg == COUNTING && bus.oneHzEnable) begin
         remaining_next = remaining_reg - (VALUE_WIDTH+1)'(1);
         if (remaining_reg == (VALUE_WIDTH+1)'(1)) begin
            state_next   = IDLE;
            expired_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (systemReset) begin
         state_reg         <= IDLE;
         remaining_reg     <= '0;
         expired_reg       <= 1'b0;
         program_error_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         remaining_reg     <= remaining_next;
         expired_reg       <= expired_next;
         program_error_reg <= bus.reprogram && write_reject;
      end
   end

   assign bus.remaining    = remaining_reg;
   assign bus.timerBusy    = (state_reg == COUNTING);
   assign bus.expired      = expired_reg;
   assign bus.programError = program_error_reg;
endmodule

// File: tb/tb_time_parameter_timer.sv
// Directed bench for time_parameter_timer: default 4-parameter instance plus a 3-parameter instance
// for out-of-range selector behaviour.
module tb_time_parameter_timer;
   logic clock = 1'b0;
   logic systemReset;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   time_parameter_timer_if #(.SEL_WIDTH(2), .VALUE_WIDTH(4)) bus4 ();
   time_parameter_timer_if #(.SEL_WIDTH(2), .VALUE_WIDTH(4)) bus3 ();

   time_parameter_timer dut (
      .clock       (clock),
      .systemReset (systemReset),
      .bus         (bus4.slave)
   );

   time_parameter_timer #(
      .NUM_PARAMS (3),
      .SEL_WIDTH  (2),
      .VALUE_WIDTH(4),
      .DEFAULTS   ({4'd15, 4'd8, 4'd6})
   ) dut3 (
      .clock       (clock),
      .systemReset (systemReset),
      .bus         (bus3.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic read4(input int idx, input int exp, input string tag);
      bus4.interval = 2'(idx);
      #1;
      check(tag, 32'(bus4.value), exp);
   endtask

   task automatic tick4();
      bus4.oneHzEnable = 1'b1;
      cyc();
      bus4.oneHzEnable = 1'b0;
   endtask

   int defaults_q[4] = '{6, 8, 15, 10};
   int prog_q[4]     = '{7, 4, 14, 9};

   initial begin
      systemReset = 1'b1;
      {bus4.oneHzEnable, bus4.reprogram, bus4.startTimer, bus4.doubleTime, bus4.abortTimer} = '0;
      {bus3.oneHzEnable, bus3.reprogram, bus3.startTimer, bus3.doubleTime, bus3.abortTimer} = '0;
      bus4.timeParameterSelector = '0; bus4.timeValue = '0; bus4.interval = '0;
      bus3.timeParameterSelector = '0; bus3.timeValue = '0; bus3.interval = '0;
      cyc();
      systemReset = 1'b0;

      check("reset_remaining", 32'(bus4.remaining), 0);
      check("reset_busy", 32'(bus4.timerBusy), 0);
      check("reset_expired", 32'(bus4.expired), 0);
      check("reset_perr", 32'(bus4.programError), 0);
      for (int i = 0; i < 4; i++) read4(i, defaults_q[i], $sformatf("default_%0d", i));

      for (int i = 0; i < 4; i++) begin
         bus4.reprogram = 1'b1;
         bus4.timeParameterSelector = 2'(i);
         bus4.timeValue = 4'(prog_q[i]);
         cyc();
         check($sformatf("write_perr_%0d", i), 32'(bus4.programError), 0);
      end
      bus4.reprogram = 1'b0;
      for (int i = 0; i < 4; i++) read4(i, prog_q[i], $sformatf("prog_%0d", i));

      systemReset = 1'b1;
      cyc();
      systemReset = 1'b0;
      for (int i = 0; i < 4; i++) read4(i, defaults_q[i], $sformatf("rst_default_%0d", i));

      // zero-value write is rejected
      bus4.reprogram = 1'b1; bus4.timeParameterSelector = 2'd1; bus4.timeValue = 4'd0;
      cyc();
      bus4.reprogram = 1'b0;
      check("zero_write_perr", 32'(bus4.programError), 1);
      cyc();
      check("zero_write_perr_drop", 32'(bus4.programError), 0);
      read4(1, 8, "zero_write_keep");

      // out-of-range selector on the 3-parameter instance
      bus3.reprogram = 1'b1; bus3.timeParameterSelector = 2'd3; bus3.timeValue = 4'd5;
      cyc();
      bus3.reprogram = 1'b0;
      check("oor_write_perr", 32'(bus3.programError), 1);
      cyc();
      check("oor_write_perr_drop", 32'(bus3.programError), 0);
      for (int i = 0; i < 3; i++) begin
         bus3.interval = 2'(i);
         #1;
         check($sformatf("oor_keep_%0d", i), 32'(bus3.value), defaults_q[i]);
      end
      bus3.interval = 2'd3;
      #1;
      check("oor_read_zero", 32'(bus3.value), 0);
      bus3.startTimer = 1'b1;
      cyc();
      bus3.startTimer = 1'b0;
      check("zero_load_expired", 32'(bus3.expired), 1);
      check("zero_load_busy", 32'(bus3.timerBusy), 0);
      cyc();
      check("zero_load_expired_drop", 32'(bus3.expired), 0);

      // basic count from arm delay (6)
      bus4.interval = 2'd0; bus4.startTimer = 1'b1;
      cyc();
      bus4.startTimer = 1'b0;
      check("start_busy", 32'(bus4.timerBusy), 1);
      check("start_remaining", 32'(bus4.remaining), 6);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         check($sformatf("idle_cycle_rem_%0d", k), 32'(bus4.remaining), 7 - k);
         tick4();
         check($sformatf("count_rem_%0d", k), 32'(bus4.remaining), 6 - k);
         check($sformatf("count_expired_%0d", k), 32'(bus4.expired), (k == 6) ? 1 : 0);
         check($sformatf("count_busy_%0d", k), 32'(bus4.timerBusy), (k == 6) ? 0 : 1);
      end
      cyc();
      check("expired_one_cycle", 32'(bus4.expired), 0);

      // doubled load of passenger delay (15 -> 30), then abort
      bus4.interval = 2'd2; bus4.doubleTime = 1'b1; bus4.startTimer = 1'b1;
      cyc();
      bus4.startTimer = 1'b0; bus4.doubleTime = 1'b0;
      check("double_remaining", 32'(bus4.remaining), 30);
      bus4.abortTimer = 1'b1;
      cyc();
      bus4.abortTimer = 1'b0;
      check("abort_remaining", 32'(bus4.remaining), 0);
      check("abort_busy", 32'(bus4.timerBusy), 0);

      // reprogram during count does not alter the running count
      bus4.startTimer = 1'b1;
      cyc();
      bus4.startTimer = 1'b0;
      check("single_remaining", 32'(bus4.remaining), 15);
      bus4.reprogram = 1'b1; bus4.timeParameterSelector = 2'd2; bus4.timeValue = 4'd3;
      tick4();
      bus4.reprogram = 1'b0;
      check("reprog_mid_rem", 32'(bus4.remaining), 14);
      read4(2, 3, "reprog_mid_value");
      for (int k = 0; k < 11; k++) tick4();
      check("pre_abort_rem", 32'(bus4.remaining), 3);

      // abort beats a same-cycle tick
      bus4.abortTimer = 1'b1;
      tick4();
      bus4.abortTimer = 1'b0;
      check("abort_tick_rem", 32'(bus4.remaining), 0);
      check("abort_tick_expired", 32'(bus4.expired), 0);
      check("abort_tick_busy", 32'(bus4.timerBusy), 0);
      cyc();
      check("abort_tick_expired_late", 32'(bus4.expired), 0);

      // restart beats a same-cycle tick at remaining=1
      bus4.interval = 2'd2; bus4.startTimer = 1'b1;
      cyc();
      bus4.startTimer = 1'b0;
      tick4();
      tick4();
      check("pre_restart_rem", 32'(bus4.remaining), 1);
      bus4.interval = 2'd1; bus4.startTimer = 1'b1;
      tick4();
      bus4.startTimer = 1'b0;
      check("restart_rem", 32'(bus4.remaining), 8);
      check("restart_expired", 32'(bus4.expired), 0);
      check("restart_busy", 32'(bus4.timerBusy), 1);
      cyc();
      check("restart_expired_late", 32'(bus4.expired), 0);

      // reset mid-count
      tick4();
      check("pre_reset_rem", 32'(bus4.remaining), 7);
      systemReset = 1'b1;
      tick4();
      systemReset = 1'b0;
      check("midreset_rem", 32'(bus4.remaining), 0);
      check("midreset_busy", 32'(bus4.timerBusy), 0);
      check("midreset_expired", 32'(bus4.expired), 0);
      cyc();
      check("midreset_expired_late", 32'(bus4.expired), 0);
      read4(2, 15, "midreset_value");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/time_parameter_timer.md
Name: time_parameter_timer

Overview:
Parametrised successor to the anti-theft time-parameter store. Holds NUM_PARAMS reprogrammable time parameters (arm delay, driver delay, passenger delay, alarm-on in the default configuration). Adds an integrated seconds countdown timer that loads a selected parameter, optionally doubled, and reports expiry. It sits between the anti-theft control FSM, which starts and aborts timers and reads expiry, and the owner reprogramming interface.

Parameters:
NUM_PARAMS, 4, number of stored time parameters
SEL_WIDTH, 2, selector width; must satisfy 2**SEL_WIDTH >= NUM_PARAMS
VALUE_WIDTH, 4, width of each parameter in seconds
DEFAULTS, {4'd10,4'd15,4'd8,4'd6}, packed reset values, index 0 in LSBs (arm=6, driver=8, passenger=15, alarm=10)

Ports:
clock  input  1  system clock; all state updates on rising edge
systemReset  input  1  synchronous, active-high reset
oneHzEnable  input  1  single-cycle 1 Hz tick from the divider
reprogram  input  1  write strobe for the parameter store
timeParameterSelector  input  SEL_WIDTH  parameter index to write
timeValue  input  VALUE_WIDTH  value to write
interval  input  SEL_WIDTH  parameter index to read and load
value  output  VALUE_WIDTH  stored parameter at interval (combinational)
startTimer  input  1  load the timer from interval
doubleTime  input  1  sampled with startTimer; loads 2×value
abortTimer  input  1  cancel the running timer
remaining  output  VALUE_WIDTH+1  current count
timerBusy  output  1  high while in COUNTING
expired  output  1  one-cycle pulse on reaching zero
programError  output  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (synchronous, clock edge with systemReset=1): regs[i]=DEFAULTS[i]. State=IDLE, remaining=0, timerBusy=0, expired=0, programError=0. Reset overrides every other input that cycle.
- Write: on an edge with reprogram=1, write timeValue into regs[timeParameterSelector]. The write is rejected (no change, programError=1 next cycle) if timeValue==0 or timeParameterSelector>=NUM_PARAMS. Data is visible on value from the cycle after the edge.
- Read: value=regs[interval] combinationally. interval>=NUM_PARAMS returns 0.
- Load width: the count register is VALUE_WIDTH+1 bits. doubleTime=1 loads {value,1'b0}, so it cannot overflow.
- FSM states: IDLE, COUNTING.
- IDLE: startTimer=1 loads remaining and moves to COUNTING. A loaded value of 0 (interval out of range) instead pulses expired next cycle and stays in IDLE.
- COUNTING: each oneHzEnable decrements remaining. The tick that takes remaining from 1 to 0 pulses expired in the following cycle and returns the FSM to IDLE.
- Priority each edge: systemReset > abortTimer > startTimer > oneHzEnable tick.
  - abortTimer: go to IDLE, remaining=0, no expired pulse.
  - startTimer while COUNTING: restart. Reload from the current interval and doubleTime, and ignore a same-cycle tick.
- A reprogram during COUNTING does not alter the running count; it affects only the next load. Reprogram and timer operation are independent and may occur in the same cycle.
- timerBusy = (state==COUNTING). expired and programError are registered, one-cycle pulses.
- Latency:
  - start to timerBusy: 1 cycle.
  - final tick to expired: 1 cycle.
  - reset mid-count: timer cleared at that edge, no expired pulse.

Test Plan:
- Reset, then sweep interval 0..3 -> value = 6, 8, 15, 10. remaining=0, timerBusy=0.
- Reprogram sel0=7, sel1=4, sel2=14, sel3=9 -> reads return 7, 4, 14, 9. Then systemReset -> reads return 6, 8, 15, 10.
- Rejected writes:
  - Write sel1=0 -> programError pulses 1 cycle, value@1 stays 8.
  - With NUM_PARAMS=3: write sel3 -> programError pulses 1 cycle, no register changes.
- Basic count: interval=0, startTimer, 6 oneHzEnable ticks -> remaining counts 6..0, expired pulses once, exactly 1 cycle after the 6th tick, timerBusy falls.
- Double time: doubleTime=1, interval=2 -> remaining=30. Start with interval=2 (value 15) -> remaining 15 loads -> a reprogram of sel2 during the count leaves the count unchanged.
- Priority:
  - abortTimer with a same-cycle tick at remaining=3 -> IDLE, no expired.
  - startTimer with a same-cycle tick at remaining=1 -> reload, no expired.
  - systemReset mid-count -> remaining=0, no expired.
